avg_sample_feeder: RTL and testbench
====================================

Name: avg_sample_feeder

Overview:
- Transmit-side partner of the 8-sample moving averager.
- Accepts 8-bit samples from upstream over a valid/ready handshake and buffers them in a small FIFO.
- Presents one sample per PERIOD-cycle window on num_out, phase-aligned with the averager's 8-state sequencer; the averager captures num_out on the last cycle of each window.
- Reports underrun when a window's capture finds the FIFO empty.

Parameters:
- WIDTH, 8, sample width in bits.
- DEPTH, 4, FIFO depth in entries; power of 2, minimum 2.
- PERIOD, 8, cycles per presentation window; must equal the averager's state count.

Ports:
- clk, input, 1, rising-edge clock.
- rs, input, 1, synchronous active-high reset.
- in_data, input, WIDTH, upstream sample.
- in_valid, input, 1, upstream sample valid.
- in_ready, output, 1, feeder can accept; combinational = (fifo_count != DEPTH).
- num_out, output, WIDTH, registered sample presented to the averager's num_in.
- slot, output, 1, high on the window's capture cycle; combinational = (phase == PERIOD-1).
- phase, output, 3, current window phase 0..PERIOD-1.
- fifo_count, output, clog2(DEPTH)+1, entries held.
- underrun, output, 1, sticky; set on any underrun, cleared only by rs.
- underrun_cnt, output, 8, underrun events, saturating at 255.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rs, sampled on the rising edge.
- Reset values: phase=0, fifo_count=0, read/write pointers=0, num_out=0, underrun=0, underrun_cnt=0.
- rs asserted mid-operation discards all FIFO contents and restarts the window at phase 0.
- The first cycle after rs deasserts is phase 0.
- phase counter: increments by 1 every cycle and wraps PERIOD-1 -> 0. It is free-running and never stalls.
- Push: on an edge with in_valid && in_ready, in_data is written at the write pointer, the pointer wraps modulo DEPTH, and fifo_count increments.
- Pop (window boundary): on an edge with slot=1, the consumer captures the current num_out. On the same edge:
  - If fifo_count != 0: num_out <= FIFO head, read pointer advances, fifo_count decrements.
  - If fifo_count == 0: num_out holds its value, underrun <= 1, and underrun_cnt increments unless already 255.
- num_out changes only on slot edges or on reset. It is therefore stable for a full PERIOD window before each capture.
- Latency: a sample pushed at least one edge before a slot edge, into an empty FIFO, appears on num_out after that slot edge. The averager captures it on the following slot edge.
- Simultaneous push and pop with FIFO non-empty and non-full: both occur and fifo_count is unchanged.
- Full FIFO (fifo_count == DEPTH): in_ready=0 even on a slot edge. There is no same-cycle bypass. in_ready rises on the cycle after the pop.
- Empty FIFO with push and slot on the same edge: the pop sees empty, so the underrun is counted. The pushed word enters the FIFO and fifo_count goes 0 -> 1. There is no bypass to num_out.
- in_data and in_valid are ignored while in_ready=0. Upstream must hold in_data stable until accepted.
- Pointers use an extra wrap bit or the explicit count; fifo_count never exceeds DEPTH and never underflows.

Test Plan:
1. Release rs; push 10, 20, 30 on cycles 0-2 -> in_ready stays 1 and fifo_count=3. Slot edges fall at cycles 7, 15, 23, 31.
   - num_out=10 after the cycle-7 edge, 20 after cycle 15, 30 after cycle 23.
   - At cycle 31, num_out stays 30, underrun=1, underrun_cnt=1.
2. Push 1-5 continuously from cycle 0 (DEPTH=4) -> 1-4 accepted; fifo_count=4 and in_ready=0 from cycle 4.
   - 5 is held until the cycle-7 pop; in_ready=1 at cycle 8 and 5 is accepted at cycle 8.
   - num_out=1 after the cycle-7 edge.
3. fifo_count=0; present in_valid with value 0x55 exactly on a slot edge -> underrun_cnt increments, fifo_count=1, num_out unchanged.
   - num_out=0x55 after the next slot edge.
4. FIFO holds 2 entries at phase 5; assert rs for one cycle -> next cycle phase=0, fifo_count=0, num_out=0, underrun=0, underrun_cnt=0, in_ready=1.
5. Leave the FIFO empty for 300 windows -> underrun_cnt saturates at 255 and stays 255; underrun=1 throughout.
6. Steady stream of one push per 8 cycles (values 0x00-0xFF incrementing) -> no underrun, fifo_count never exceeds 1.
   - num_out follows the input sequence in order, changing only on slot edges.

Source files
------------

// File: rtl/avg_sample_feeder.sv
// avg_sample_feeder: buffers upstream samples in a small FIFO and presents
// one sample per PERIOD-cycle window on num_out, aligned to the averager's
// sequencer. The averager captures num_out on the slot cycle; the same edge
// loads the next FIFO head or, if the FIFO is empty, records an underrun.
module avg_sample_feeder #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 8
) (
  input  logic                     clk,
  input  logic                     rs,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         num_out,
  output logic                     slot,
  output logic [2:0]               phase,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     underrun,
  output logic [7:0]               underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [2:0]    PH_LAST = 3'(PERIOD - 1);

  // Saturating increment for the 8-bit underrun event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       phase_q, phase_d;
  logic [WIDTH-1:0] num_out_q, num_out_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       ur_cnt_q, ur_cnt_d;

  logic push, pop, ur_evt, slot_now, ready_now;

  assign ready_now = (count_q != FULL);
  assign slot_now  = (phase_q == PH_LAST);

  // Next-state: phase counter, FIFO push/pop bookkeeping, window load and underrun tracking.
  always_comb begin
    push       = in_valid && ready_now;
    pop        = slot_now && (count_q != '0);
    ur_evt     = slot_now && (count_q == '0);

    phase_d    = slot_now ? 3'd0 : phase_q + 3'd1;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    num_out_d  = pop ? mem_q[rd_ptr_q] : num_out_q;
    underrun_d = underrun_q | ur_evt;
    ur_cnt_d   = ur_evt ? sat_inc8(ur_cnt_q) : ur_cnt_q;
  end

  // Control and presentation registers; reset discards FIFO contents and restarts the window.
  always_ff @(posedge clk) begin
    if (rs) begin
      phase_q    <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      num_out_q  <= '0;
      underrun_q <= 1'b0;
      ur_cnt_q   <= 8'd0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      num_out_q  <= num_out_d;
      underrun_q <= underrun_d;
      ur_cnt_q   <= ur_cnt_d;
    end
  end

  // FIFO storage is written on accepted pushes only; stale words are never read.
  always_ff @(posedge clk) begin
    if (!rs && push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready     = ready_now;
  assign slot         = slot_now;
  assign phase        = phase_q;
  assign fifo_count   = count_q;
  assign num_out      = num_out_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ur_cnt_q;

endmodule

// File: tb/tb_avg_sample_feeder.sv
// Bench for avg_sample_feeder: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_avg_sample_feeder;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 8;

  logic                   clk = 1'b0;
  logic                   rs = 1'b0;
  logic [WIDTH-1:0]       in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       num_out;
  logic                   slot;
  logic [2:0]             phase;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   underrun;
  logic [7:0]             underrun_cnt;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  avg_sample_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk(clk), .rs(rs), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .num_out(num_out), .slot(slot), .phase(phase),
    .fifo_count(fifo_count), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: FIFO as a queue, window position as a cycle count mod PERIOD.
  int        mq[$];
  int        ph_m = 0;
  int        num_m = 0;
  bit        ur_m = 0;
  int        cnt_m = 0;

  always @(posedge clk) begin
    int pre_size;
    if (rs) begin
      mq.delete();
      ph_m = 0; num_m = 0; ur_m = 0; cnt_m = 0;
    end else begin
      pre_size = mq.size();
      if (ph_m == PERIOD - 1) begin
        if (pre_size != 0) num_m = mq.pop_front();
        else begin
          ur_m = 1;
          if (cnt_m < 255) cnt_m = cnt_m + 1;
        end
      end
      if (in_valid && pre_size != DEPTH) mq.push_back(int'(in_data));
      ph_m = (ph_m + 1) % PERIOD;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      check("m_slot", 32'(slot), 32'(ph_m == PERIOD - 1));
      check("m_phase", 32'(phase), 32'(ph_m));
      check("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("m_num_out", 32'(num_out), 32'(num_m));
      check("m_underrun", 32'(underrun), 32'(ur_m));
      check("m_underrun_cnt", 32'(underrun_cnt), 32'(cnt_m));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Leaves the bench in cycle 0 (phase 0) with rs low.
  task automatic do_reset();
    @(posedge clk); #2;
    rs = 1'b1; in_valid = 1'b0;
    step();
    rs = 1'b0;
  endtask

  int maxc;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_phase", 32'(phase), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_num_out", 32'(num_out), 0);

    // Scenario 1: three samples, then an underrun on the fourth window.
    in_valid = 1; in_data = 8'd10; step();
    in_data = 8'd20; step();
    in_data = 8'd30; step();
    in_valid = 0;
    check("s1_count3", 32'(fifo_count), 3);
    check("s1_ready", 32'(in_ready), 1);
    step(5);  // cycle 8
    check("s1_num10", 32'(num_out), 10);
    step(8);
    check("s1_num20", 32'(num_out), 20);
    step(8);
    check("s1_num30", 32'(num_out), 30);
    check("s1_empty", 32'(fifo_count), 0);
    step(8);
    check("s1_hold30", 32'(num_out), 30);
    check("s1_underrun", 32'(underrun), 1);
    check("s1_ur_cnt", 32'(underrun_cnt), 1);

    // Scenario 2: overfill, fifth sample held until the window pop frees space.
    do_reset();
    in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i); step();
    end
    in_data = 8'd5;
    check("s2_full", 32'(fifo_count), 4);
    check("s2_not_ready", 32'(in_ready), 0);
    step(3);  // cycle 7
    check("s2_not_ready_slot", 32'(in_ready), 0);
    step();   // cycle 8
    check("s2_ready_after_pop", 32'(in_ready), 1);
    check("s2_num1", 32'(num_out), 1);
    check("s2_count3", 32'(fifo_count), 3);
    step();
    in_valid = 0;
    check("s2_accept5", 32'(fifo_count), 4);

    // Scenario 3: push coinciding with an empty-FIFO slot edge.
    do_reset();
    step(7);
    in_valid = 1; in_data = 8'h55;
    step();
    in_valid = 0;
    check("s3_ur_cnt", 32'(underrun_cnt), 1);
    check("s3_count1", 32'(fifo_count), 1);
    check("s3_num_hold", 32'(num_out), 0);
    step(8);
    check("s3_num55", 32'(num_out), 32'h55);

    // Scenario 4: mid-window reset with two entries held and an underrun recorded.
    in_valid = 1; in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_valid = 0;
    step(3);
    check("s4_phase5", 32'(phase), 5);
    check("s4_count2", 32'(fifo_count), 2);
    rs = 1; step(); rs = 0;
    check("s4_phase0", 32'(phase), 0);
    check("s4_count0", 32'(fifo_count), 0);
    check("s4_num0", 32'(num_out), 0);
    check("s4_ur0", 32'(underrun), 0);
    check("s4_urcnt0", 32'(underrun_cnt), 0);
    check("s4_ready", 32'(in_ready), 1);

    // Scenario 5: 300 empty windows saturate the counter.
    step(8);
    check("s5_first", 32'(underrun_cnt), 1);
    step(299 * 8);
    check("s5_sat", 32'(underrun_cnt), 255);
    check("s5_ur", 32'(underrun), 1);

    // Scenario 6: one push per window streams through without underrun.
    do_reset();
    maxc = 0;
    for (int v = 0; v < 256; v++) begin
      in_valid = 1; in_data = 8'(v);
      step();
      in_valid = 0;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      step(7);
      check("s6_num", 32'(num_out), 32'(v));
    end
    check("s6_max_count", 32'(maxc), 1);
    check("s6_no_ur", 32'(underrun), 0);
    check("s6_urcnt", 32'(underrun_cnt), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
